key_filter: RTL

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_pkg.sv | 19 +
 rtl/key_sync.sv | 24 ++
 rtl/key_filter.sv | 112 +++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and default timing.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILTER_DN = 2'd1,
        DOWN      = 2'd2,
        FILTER_UP = 2'd3
    } fsm_state_t;

    // 20 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Map the raw pin level onto pressed = 1.
    function automatic logic is_pressed(input logic level, input bit active_low);
        return active_low ? ~level : level;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous key pin.
module key_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Resolve metastability over two stages; reset to the idle pin level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_filter.sv
// Key debouncer: synchronizes the raw key, requires a stable window before
// confirming a press or release, and emits one-cycle registered strobes.
module key_filter
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_release,
    output logic key_state
);

    localparam int unsigned      CNT_W          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             RELEASED_LEVEL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic             synced;
    logic             pressed;
    fsm_state_t       state;
    fsm_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flag_nxt;
    logic             release_nxt;
    logic             level_nxt;

    key_sync #(
        .RESET_VALUE(RELEASED_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (key_in),
        .q  (synced)
    );

    assign pressed = is_pressed(synced, KEY_ACTIVE_LOW);

    // State, window counter and all outputs are registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_flag    <= flag_nxt;
            key_release <= release_nxt;
            key_state   <= level_nxt;
        end
    end

    // Next-state logic: any opposite sample in a filter state abandons the window.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        flag_nxt    = 1'b0;
        release_nxt = 1'b0;
        level_nxt   = key_state;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = FILTER_DN;
                    cnt_nxt   = '0;
                end
            end
            FILTER_DN: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_nxt = FILTER_UP;
                    cnt_nxt   = '0;
                end
            end
            FILTER_UP: begin
                if (pressed) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
